// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file defaults and address/data typedefs
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/write-back bus of the scoreboarded register file
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [ADDR_W-1:0]       rs0;
    logic [ADDR_W-1:0]       rs1;
    logic [ADDR_W-1:0]       rd;
    logic                    r_latch;
    logic [DATA_W-1:0]       busD_in;
    logic                    res_en;
    logic [ADDR_W-1:0]       res_addr;
    logic [DATA_W-1:0]       bus0;
    logic [DATA_W-1:0]       bus1;
    logic [DATA_W-1:0]       busD_out;
    logic                    busy0;
    logic                    busy1;
    logic                    busyD;
    logic                    stall;
    logic                    res_conflict;
    logic [DATA_W*NREGS-1:0] regs_flat;

    modport master (
        output rs0, rs1, rd, r_latch, busD_in, res_en, res_addr,
        input  bus0, bus1, busD_out, busy0, busy1, busyD, stall, res_conflict, regs_flat
    );

    modport slave (
        input  rs0, rs1, rd, r_latch, busD_in, res_en, res_addr,
        output bus0, bus1, busD_out, busy0, busy1, busyD, stall, res_conflict, regs_flat
    );
endinterface

// File: rtl/regfile_sb_score.sv
// rtl/regfile_sb_score.sv - per-register pending-write bits and reserve conflict flag
module regfile_sb_score
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ZERO_R0 = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       rd,
    input  logic                    r_latch,
    input  logic                    res_en,
    input  logic [ADDR_W-1:0]       res_addr,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic                    res_conflict
);
    localparam int NREGS = 2 ** ADDR_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            res_conflict <= 1'b0;
        end else begin
            // A reserve beats a same-cycle write-back: the new owner is still pending.
            for (int i = 0; i < NREGS; i++) begin
                if (res_en && res_addr == ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if (r_latch && rd == ADDR_W'(i))
                    busy[i] <= 1'b0;
            end
            if (ZERO_R0 != 0)
                busy[0] <= 1'b0;
            res_conflict <= res_en && busy[res_addr] && !(r_latch && rd == res_addr);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write-back scoreboard; REGFILE_BYPASS_EN adds write-through reads
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              wr_ok;
    logic [ADDR_W-1:0] raddr [3];
    logic [DATA_W-1:0] rdata [3];
    logic              rbusy [3];

    assign wr_ok = bus.r_latch && !(ZERO_R0 != 0 && bus.rd == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.rd] <= bus.busD_in;
        end
    end

    regfile_sb_score #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_score (
        .clk          (clk),
        .rst          (rst),
        .rd           (bus.rd),
        .r_latch      (bus.r_latch),
        .res_en       (bus.res_en),
        .res_addr     (bus.res_addr),
        .busy         (busy),
        .res_conflict (bus.res_conflict)
    );

    assign raddr[0] = bus.rs0;
    assign raddr[1] = bus.rs1;
    assign raddr[2] = bus.rd;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = busy[raddr[p]];
`ifdef REGFILE_BYPASS_EN
            // The completing write releases the register unless it is re-reserved now.
            if (wr_ok && bus.rd == raddr[p]) begin
                rdata[p] = bus.busD_in;
                rbusy[p] = bus.res_en && bus.res_addr == raddr[p];
            end
`endif
            if (ZERO_R0 != 0 && raddr[p] == '0) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.bus0     = rdata[0];
    assign bus.bus1     = rdata[1];
    assign bus.busD_out = rdata[2];
    assign bus.busy0    = rbusy[0];
    assign bus.busy1    = rbusy[1];
    assign bus.busyD    = rbusy[2];
    assign bus.stall    = rbusy[0] | rbusy[1];

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign bus.regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
